compute_cluster_seq: RTL and testbench

- Parametrised sequencing controller for a cluster of CU_NUM compute units.
- Routes filter-chunk write beats to one CU at a time (auto-advancing pointer) or to all CUs (broadcast).
- Collects per-CU finish pulses into a masked, sticky barrier and emits one cluster-finish pulse per round.
- Drains the enabled CUs' output buffers in index order over a valid/ready stream, one beat per CU.

---
 rtl/compute_cluster_seq.sv | 197 +++++++++++++++++++
 tb/tb_compute_cluster_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_cluster_seq.sv
// Cluster sequencer: routes filter write beats to the compute units, gathers their
// finish pulses into a per-round barrier, and drains the enabled CUs' outputs as a stream.
module compute_cluster_seq #(
  parameter int CU_NUM     = 8,
  parameter int OUT_W      = 256,
  parameter int WR_CYC_NUM = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fil_wr_valid_i,
  input  logic [$clog2(WR_CYC_NUM)-1:0] fil_wr_count_i,
  input  logic                          fil_bcast_i,
  output logic [CU_NUM-1:0]             cu_fil_wr_valid_o,
  output logic                          fil_load_done_o,
  input  logic [CU_NUM-1:0]             cu_enable_mask_i,
  input  logic [CU_NUM-1:0]             cu_finish_i,
  output logic                          all_finish_o,
  input  logic                          auto_drain_i,
  input  logic                          drain_start_i,
  input  logic [CU_NUM*OUT_W-1:0]       cu_out_dat_i,
  output logic [OUT_W-1:0]              out_dat_o,
  output logic [$clog2(CU_NUM)-1:0]     out_cu_idx_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic                          busy_o,
  output logic                          drain_ovf_o
);

  localparam int IW = $clog2(CU_NUM);
  localparam int CW = $clog2(WR_CYC_NUM);

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [IW-1:0] lowest_idx(input logic [CU_NUM-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = CU_NUM - 1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] highest_idx(input logic [CU_NUM-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < CU_NUM; i++) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Keeps only the mask bits strictly above index p.
  function automatic logic [CU_NUM-1:0] above_mask(input logic [CU_NUM-1:0] m,
                                                   input logic [IW-1:0] p);
    logic [CU_NUM-1:0] r;
    for (int i = 0; i < CU_NUM; i++) begin
      r[i] = m[i] && (IW'(i) > p);
    end
    return r;
  endfunction

  logic [IW-1:0]     wptr_q, wptr_d;
  logic              load_done_q, load_done_d;
  logic [CU_NUM-1:0] sticky_q, sticky_d;
  logic              all_finish_q, all_finish_d;
  state_t            state_q;
  logic [CU_NUM-1:0] dmask_q;
  logic              pending_q, ovf_q;
  logic [OUT_W-1:0]  out_dat_q;
  logic [IW-1:0]     out_idx_q;
  logic              out_valid_q, out_last_q;

  logic              mask_any, beat_last, drain_go;
  logic [CU_NUM-1:0] wr_above, fin_nxt;
  logic [IW-1:0]     first_idx, next_idx;
  logic              first_is_last, next_is_last;
  logic [OUT_W-1:0]  cu_word [CU_NUM];

  assign mask_any = |cu_enable_mask_i;

  generate
    for (genvar gi = 0; gi < CU_NUM; gi++) begin : g_cu
      assign cu_word[gi] = cu_out_dat_i[gi*OUT_W +: OUT_W];
      assign cu_fil_wr_valid_o[gi] = ~rst_i & fil_wr_valid_i &
          (fil_bcast_i ? cu_enable_mask_i[gi] : (mask_any && (wptr_q == IW'(gi))));
    end
  endgenerate

  // A wrap of the write pointer means the highest enabled CU just got its last beat.
  always_comb begin
    beat_last   = fil_wr_valid_i && mask_any && (fil_wr_count_i == CW'(WR_CYC_NUM - 1));
    wr_above    = above_mask(cu_enable_mask_i, wptr_q);
    wptr_d      = wptr_q;
    load_done_d = 1'b0;
    if (beat_last) begin
      if (fil_bcast_i) begin
        load_done_d = 1'b1;
      end else if (|wr_above) begin
        wptr_d = lowest_idx(wr_above);
      end else begin
        wptr_d      = lowest_idx(cu_enable_mask_i);
        load_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    fin_nxt      = sticky_q | (cu_finish_i & cu_enable_mask_i);
    all_finish_d = mask_any && (&(fin_nxt | ~cu_enable_mask_i));
    sticky_d     = all_finish_d ? '0 : fin_nxt;
  end

  always_comb begin
    drain_go      = drain_start_i | (auto_drain_i & all_finish_q);
    first_idx     = lowest_idx(cu_enable_mask_i);
    first_is_last = (first_idx == highest_idx(cu_enable_mask_i));
    next_idx      = lowest_idx(above_mask(dmask_q, out_idx_q));
    next_is_last  = (next_idx == highest_idx(dmask_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      load_done_q  <= 1'b0;
      sticky_q     <= '0;
      all_finish_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      load_done_q  <= load_done_d;
      sticky_q     <= sticky_d;
      all_finish_q <= all_finish_d;
    end
  end

  // Drain FSM; a late pending_q clear in SEND deliberately overrides the earlier set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dmask_q     <= '0;
      pending_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_dat_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_go && mask_any) begin
            dmask_q     <= cu_enable_mask_i;
            out_dat_q   <= cu_word[first_idx];
            out_idx_q   <= first_idx;
            out_last_q  <= first_is_last;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (drain_go) begin
            if (pending_q) ovf_q <= 1'b1;
            else           pending_q <= 1'b1;
          end
          if (out_ready_i) begin
            if (!out_last_q) begin
              out_dat_q  <= cu_word[next_idx];
              out_idx_q  <= next_idx;
              out_last_q <= next_is_last;
            end else if ((pending_q || drain_go) && mask_any) begin
              pending_q  <= 1'b0;
              dmask_q    <= cu_enable_mask_i;
              out_dat_q  <= cu_word[first_idx];
              out_idx_q  <= first_idx;
              out_last_q <= first_is_last;
            end else begin
              pending_q   <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fil_load_done_o = load_done_q;
  assign all_finish_o    = all_finish_q;
  assign out_dat_o       = out_dat_q;
  assign out_cu_idx_o    = out_idx_q;
  assign out_valid_o     = out_valid_q;
  assign out_last_o      = out_last_q;
  assign busy_o          = (state_q == SEND);
  assign drain_ovf_o     = ovf_q;

endmodule

// File: tb/tb_compute_cluster_seq.sv
// Bench for compute_cluster_seq: routing table, hand-written barrier/drain/reset
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_compute_cluster_seq;
  localparam int CU_NUM = 8;
  localparam int OUT_W = 32;
  localparam int WR_CYC_NUM = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic                    fil_wr_valid_i = 1'b0;
  logic [2:0]              fil_wr_count_i = '0;
  logic                    fil_bcast_i = 1'b0;
  logic [CU_NUM-1:0]       cu_fil_wr_valid_o;
  logic                    fil_load_done_o;
  logic [CU_NUM-1:0]       cu_enable_mask_i = '0;
  logic [CU_NUM-1:0]       cu_finish_i = '0;
  logic                    all_finish_o;
  logic                    auto_drain_i = 1'b0;
  logic                    drain_start_i = 1'b0;
  logic [CU_NUM*OUT_W-1:0] cu_out_dat_i = '0;
  logic [OUT_W-1:0]        out_dat_o;
  logic [2:0]              out_cu_idx_o;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic                    out_last_o;
  logic                    busy_o;
  logic                    drain_ovf_o;

  compute_cluster_seq #(.CU_NUM(CU_NUM), .OUT_W(OUT_W), .WR_CYC_NUM(WR_CYC_NUM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fil_wr_valid_i(fil_wr_valid_i), .fil_wr_count_i(fil_wr_count_i), .fil_bcast_i(fil_bcast_i),
    .cu_fil_wr_valid_o(cu_fil_wr_valid_o), .fil_load_done_o(fil_load_done_o),
    .cu_enable_mask_i(cu_enable_mask_i), .cu_finish_i(cu_finish_i), .all_finish_o(all_finish_o),
    .auto_drain_i(auto_drain_i), .drain_start_i(drain_start_i), .cu_out_dat_i(cu_out_dat_i),
    .out_dat_o(out_dat_o), .out_cu_idx_o(out_cu_idx_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o), .drain_ovf_o(drain_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_wptr;
  logic [7:0]  m_seen;
  bit          m_done, m_allfin, m_busy, m_pending, m_ovf;
  int          m_q[$];
  logic [31:0] m_data;

  // observed handshakes
  int hs_idx[$];
  int hs_last[$];

  typedef struct packed {
    logic       valid;
    logic       bcast;
    logic [2:0] cnt;
    logic [7:0] mask;
    logic [7:0] exp_str;
    logic       exp_done;
  } rvec_t;
  rvec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int idx);
    return cu_out_dat_i[idx*OUT_W +: OUT_W];
  endfunction

  task automatic fill(input logic [7:0] m);
    m_q.delete();
    for (int i = 0; i < CU_NUM; i++) if (m[i]) m_q.push_back(i);
  endtask

  task automatic model_reset();
    m_wptr = 0; m_seen = '0; m_done = 0; m_allfin = 0;
    m_busy = 0; m_pending = 0; m_ovf = 0; m_data = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [7:0] m;
    bit any, start, done_n, fin_n;
    int j;
    m = cu_enable_mask_i;
    any = (m != 0);
    start = drain_start_i | (auto_drain_i & m_allfin);
    done_n = 0;
    fin_n = 0;
    if (fil_wr_valid_i && fil_wr_count_i == 3'd7 && any) begin
      if (fil_bcast_i) done_n = 1;
      else begin
        j = -1;
        for (int k = CU_NUM - 1; k > m_wptr; k--) if (m[k]) j = k;
        if (j < 0) begin
          for (int k = CU_NUM - 1; k >= 0; k--) if (m[k]) j = k;
          done_n = 1;
        end
        m_wptr = j;
      end
    end
    m_seen = m_seen | (cu_finish_i & m);
    if (any && ((m_seen & m) == m)) begin
      m_seen = '0;
      fin_n = 1;
    end
    if (!m_busy) begin
      if (start && any) begin
        fill(m);
        m_busy = 1;
        m_data = word(m_q[0]);
      end
    end else begin
      if (start) begin
        if (m_pending) m_ovf = 1;
        else m_pending = 1;
      end
      if (out_ready_i) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (m_pending) begin
            m_pending = 0;
            if (any) fill(m);
          end
          if (m_q.size() == 0) m_busy = 0;
        end
        if (m_q.size() != 0) m_data = word(m_q[0]);
      end
    end
    m_done = done_n;
    m_allfin = fin_n;
  endtask

  // One clock: settle inputs, check combinational strobes, step model, clock, check registers.
  task automatic cycle();
    logic [7:0] es;
    for (int c = 0; c < CU_NUM; c++) cu_out_dat_i[c*OUT_W +: OUT_W] = $urandom;
    #1;
    es = '0;
    if (fil_wr_valid_i)
      es = fil_bcast_i ? cu_enable_mask_i : ((cu_enable_mask_i != 0) ? (8'h1 << m_wptr) : 8'h0);
    chk("strobe", cu_fil_wr_valid_o, es);
    if (out_valid_o && out_ready_i) begin
      hs_idx.push_back(int'(out_cu_idx_o));
      hs_last.push_back(int'(out_last_o));
      $display("beat idx=%0d last=%0d data=%08h", out_cu_idx_o, out_last_o, out_dat_o);
    end
    model_step();
    @(posedge clk_i);
    #1;
    chk("load_done", fil_load_done_o, m_done);
    chk("all_finish", all_finish_o, m_allfin);
    chk("out_valid", out_valid_o, m_busy);
    chk("busy", busy_o, m_busy);
    chk("drain_ovf", drain_ovf_o, m_ovf);
    if (m_busy) begin
      chk("out_idx", out_cu_idx_o, m_q[0]);
      chk("out_last", out_last_o, m_q.size() == 1);
      chk("out_dat", out_dat_o, m_data);
    end
  endtask

  task automatic zero_inputs();
    fil_wr_valid_i = 0; fil_wr_count_i = '0; fil_bcast_i = 0;
    cu_finish_i = '0; auto_drain_i = 0; drain_start_i = 0; out_ready_i = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_i = 1'b1;
    #3;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", drain_ovf_o, 0);
    chk("rst_done", fil_load_done_o, 0);
    chk("rst_allfin", all_finish_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_idx", out_cu_idx_o, 0);
    chk("rst_dat", out_dat_o, 0);
    chk("rst_strobe", cu_fil_wr_valid_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    hs_idx.delete();
    hs_last.delete();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'hA5, 8'h01, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd7, 8'hA5, 8'h01, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 8'hA5, 8'h04, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd7, 8'hA5, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'd7, 8'hA5, 8'h04, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'd7, 8'hA5, 8'h20, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'd7, 8'hA5, 8'h80, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd0, 8'hA5, 8'h01, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3'd7, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 3'd7, 8'hA5, 8'hA5, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 3'd7, 8'hA5, 8'h01, 1'b0};

    model_reset();
    #2;
    do_reset();

    // sparse-mask routing table
    for (int i = 0; i < 14; i++) begin
      fil_wr_valid_i = tbl[i].valid;
      fil_bcast_i = tbl[i].bcast;
      fil_wr_count_i = tbl[i].cnt;
      cu_enable_mask_i = tbl[i].mask;
      #1;
      chk($sformatf("tbl%0d_strobe", i), cu_fil_wr_valid_o, tbl[i].exp_str);
      chk($sformatf("tbl%0d_done", i), fil_load_done_o, tbl[i].exp_done);
      cycle();
    end

    // full mask: 8 CUs x 8 beats, done one cycle after beat 64, then wrap to CU0
    do_reset();
    cu_enable_mask_i = 8'hFF;
    for (int b = 0; b < 65; b++) begin
      fil_wr_valid_i = 1;
      fil_wr_count_i = 3'(b % 8);
      #1;
      chk($sformatf("full_strobe%0d", b), cu_fil_wr_valid_o, 8'h1 << ((b / 8) % 8));
      chk($sformatf("full_done%0d", b), fil_load_done_o, b == 64);
      cycle();
    end
    zero_inputs();
    cycle();

    // barrier, mask 0F: 3,3,0,1,2 then 3,0,{1,2}
    do_reset();
    cu_enable_mask_i = 8'h0F;
    begin
      logic [7:0] fseq [8];
      fseq[0] = 8'h08; fseq[1] = 8'h08; fseq[2] = 8'h01; fseq[3] = 8'h02;
      fseq[4] = 8'h04; fseq[5] = 8'h08; fseq[6] = 8'h01; fseq[7] = 8'h06;
      for (int i = 0; i < 8; i++) begin
        cu_finish_i = fseq[i];
        cycle();
        chk($sformatf("barrier%0d", i), all_finish_o, (i == 4) || (i == 7));
      end
      cu_finish_i = '0;
      cycle();
      chk("barrier_single", all_finish_o, 0);
    end

    // auto drain with backpressure, mask 81
    do_reset();
    cu_enable_mask_i = 8'h81;
    auto_drain_i = 1;
    cu_finish_i = 8'h81;
    cycle();
    cu_finish_i = '0;
    for (int k = 0; k < 7; k++) begin
      out_ready_i = (k % 2 == 0);
      cycle();
    end
    chk("bp_hs_count", hs_idx.size(), 2);
    if (hs_idx.size() == 2) begin
      chk("bp_idx0", hs_idx[0], 0);
      chk("bp_last0", hs_last[0], 0);
      chk("bp_idx1", hs_idx[1], 7);
      chk("bp_last1", hs_last[1], 1);
    end
    chk("bp_busy_end", busy_o, 0);

    // pending replay and overflow, mask 0F
    do_reset();
    cu_enable_mask_i = 8'h0F;
    begin
      bit st [5];
      st[0] = 1; st[1] = 1; st[2] = 0; st[3] = 1; st[4] = 0;
      for (int i = 0; i < 5; i++) begin
        drain_start_i = st[i];
        cycle();
      end
    end
    drain_start_i = 0;
    chk("ovf_set", drain_ovf_o, 1);
    out_ready_i = 1;
    for (int k = 0; k < 8; k++) cycle();
    chk("pend_busy_end", busy_o, 0);
    chk("pend_hs_count", hs_idx.size(), 8);
    for (int k = 0; k < hs_idx.size() && k < 8; k++) begin
      chk($sformatf("pend_idx%0d", k), hs_idx[k], k % 4);
      chk($sformatf("pend_last%0d", k), hs_last[k], (k % 4) == 3);
    end
    out_ready_i = 0;

    // reset mid-drain (overflow flag still set from above)
    drain_start_i = 1;
    cycle();
    drain_start_i = 0;
    cycle();
    chk("pre_rst_busy", busy_o, 1);
    chk("pre_rst_ovf", drain_ovf_o, 1);
    #2;
    do_reset();
    cu_enable_mask_i = 8'h0C;
    drain_start_i = 1;
    cycle();
    drain_start_i = 0;
    chk("post_rst_idx", out_cu_idx_o, 2);
    chk("post_rst_valid", out_valid_o, 1);
    out_ready_i = 1;
    for (int k = 0; k < 3; k++) cycle();

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 64 == 0) cu_enable_mask_i = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      fil_wr_valid_i = 1'($urandom);
      fil_bcast_i = ($urandom % 4 == 0);
      fil_wr_count_i = ($urandom % 2 == 1) ? 3'd7 : 3'($urandom);
      cu_finish_i = 8'($urandom & $urandom & $urandom);
      auto_drain_i = 1'($urandom);
      drain_start_i = ($urandom % 16 == 0);
      out_ready_i = ($urandom % 3 != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
